mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and steps the shared datapath (PC, memory, IR, register file, ALU) through fetch, decode, execute, memory and writeback. Its `alu_op` output drives the ALU control decoder, which maps it together with the instruction funct field to the ALU operation. Memory accesses stall on a ready handshake, and an unsupported opcode parks the FSM in a sticky error state.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates occur on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: IR[31:26]; valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current access this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load qualified by `zero`.
- `pc_en` output 1: equals `pc_write | (pc_write_cond & zero)`.
- `pc_source` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: IR load.
- `mem_to_reg` output 1: writeback source; 1 = MDR.
- `reg_dst` output 1: destination register select; 1 = rd, 0 = rt.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_op` output 2: 00 = add, 01 = subtract, 10 = decode funct.
- `instr_done` output 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` output 1: unsupported opcode detected; stays high until reset.
- `state` output 4: current state, for debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, ILLEGAL 15.
- Outputs are decoded from the state register. Every output not listed for a state is 0.
- FETCH:
  - Outputs: `mem_read`=1, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Next state: DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE:
  - Outputs: `alu_src_b`=11, `alu_op`=00.
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX (see Configuration); any other opcode → ILLEGAL.
- MEMADR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: MEMRD for opcode 100011; MEMWR for opcode 101011.
- MEMRD:
  - Outputs: `mem_read`=1, `i_or_d`=1.
  - Next state: MEMWB when `mem_ready`=1; otherwise stay in MEMRD.
- MEMWB:
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: `mem_write`=1, `i_or_d`=1.
  - `instr_done` equals `mem_ready`.
  - Next state: FETCH when `mem_ready`=1; otherwise stay in MEMWR.
- EXEC:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - Next state: RWB.
- RWB:
  - Outputs: `reg_write`=1, `reg_dst`=1, `instr_done`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: `pc_write`=1, `pc_source`=10, `instr_done`=1.
  - Next state: FETCH.
- ADDI_EX:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: ADDI_WB.
- ADDI_WB:
  - Outputs: `reg_write`=1, `reg_dst`=0, `instr_done`=1.
  - Next state: FETCH.
- ILLEGAL:
  - Outputs: all strobes 0, `illegal`=1.
  - Next state: ILLEGAL; only reset exits.

## Timing
- On `rst`=1 (asynchronous): `state` becomes FETCH. While `rst` is high, every output is forced to 0, including `illegal` and `instr_done`.
- On the first rising edge after `rst` falls, the FSM evaluates FETCH normally.
- Reset asserted mid-instruction aborts the instruction immediately. Reset asserted in ILLEGAL clears `illegal`.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5.
  - sw: 4.
  - R-type: 4.
  - addi: 4.
  - beq: 3.
  - j: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. All strobes in those states hold steady during the stall.
- `instr_done` is high for exactly one cycle per retired instruction, and is never asserted in FETCH or DECODE.
- `opcode` is sampled only in DECODE and MEMADR, so it must stay stable from IR load until the instruction completes.

## Configuration
- Macro `MC_CTRL_ADDI_EN`.
- Defined: opcode 001000 in DECODE goes to ADDI_EX, then ADDI_WB.
- Undefined: the ADDI_EX and ADDI_WB states are not built, and opcode 001000 goes to ILLEGAL.

## Test plan
- Reset behaviour: assert `rst` mid-cycle in MEMRD → `state`=0 immediately and all outputs 0. After release, the first cycle shows `mem_read`=1 and `alu_src_b`=01.
- lw (opcode 100011) with `mem_ready`=1 → `state` sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 in state 4. `instr_done` pulses once.
- sw (opcode 101011) with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held for 4 cycles. `instr_done` is high only in the cycle where `mem_ready`=1. Total 7 cycles.
- beq (opcode 000100) → in BRANCH: `zero`=1 gives `pc_en`=1, `zero`=0 gives `pc_en`=0. `alu_op`=01 in both cases.
- R-type (opcode 000000) → `alu_op`=10 in EXEC, then `reg_dst`=1 and `reg_write`=1 in RWB. Addi (opcode 001000) with the macro defined → states 10 then 11, and `alu_op`=00.
- Opcode 111111, or 001000 with the macro undefined → `state`=15 and `illegal`=1 held for 10+ cycles with all strobes 0. `rst` clears it.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath; outputs decode from the state register.
// Optional addi support is built when MC_CTRL_ADDI_EN is defined; otherwise opcode 001000 traps to ILLEGAL.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
`ifdef MC_CTRL_ADDI_EN
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
`endif
        S_ILLEGAL = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:       state_d = S_ADDI_EX;
`endif
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Opcode changing after DECODE breaks the stability contract; trap it.
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_ILLEGAL;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase

        // Reset is asynchronous, so outputs are squashed combinationally while it is held.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction walks, stalls, branch qualification and illegal trap.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cycles;
    int dones;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    // Every output in one vector, used for "all zero" checks.
    wire [22:0] all_out = {pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read,
                           mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                           alu_src_b, alu_op, instr_done, illegal, state};
    wire [10:0] strobes = {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
                           ir_write, mem_to_reg, reg_dst, reg_write, instr_done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (instr_done === 1'b1) dones++;
        cycles++;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("reset_all_zero", {9'd0, all_out}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("post_reset_state", {28'd0, state}, 32'd0);
        chk("post_reset_mem_read", {31'd0, mem_read}, 32'd1);
        chk("post_reset_alu_src_b", {30'd0, alu_src_b}, 32'd1);
        chk("post_reset_ir_write", {31'd0, ir_write}, 32'd1);

        // FETCH stall
        mem_ready = 1'b0; #1;
        chk("fetch_stall_ir_write", {31'd0, ir_write}, 32'd0);
        chk("fetch_stall_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        chk("fetch_stall_state", {28'd0, state}, 32'd0);
        chk("fetch_stall_mem_read", {31'd0, mem_read}, 32'd1);
        mem_ready = 1'b1;

        // lw
        opcode = 6'b100011; cycles = 1; dones = 0;
        tick(); chk("lw_s1", {28'd0, state}, 32'd1);
        chk("lw_decode_alu_src_b", {30'd0, alu_src_b}, 32'd3);
        tick(); chk("lw_s2", {28'd0, state}, 32'd2);
        tick(); chk("lw_s3", {28'd0, state}, 32'd3);
        chk("lw_memrd_i_or_d", {31'd0, i_or_d}, 32'd1);
        tick(); chk("lw_s4", {28'd0, state}, 32'd4);
        chk("lw_reg_write", {31'd0, reg_write}, 32'd1);
        chk("lw_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
        tick(); chk("lw_s0", {28'd0, state}, 32'd0);
        chk("lw_cycles", cycles, 32'd6);
        chk("lw_done_pulses", dones, 32'd1);

        // Reset in the middle of MEMRD
        tick(); tick(); tick();
        chk("rst_pre_memrd", {28'd0, state}, 32'd3);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_state", {28'd0, state}, 32'd0);
        chk("rst_mid_all_zero", {9'd0, all_out}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; mem_ready = 1'b1; #1;
        chk("rst_rel_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rst_rel_alu_src_b", {30'd0, alu_src_b}, 32'd1);

        // sw with three stall cycles in MEMWR
        opcode = 6'b101011; cycles = 1; dones = 0;
        tick(); tick(); tick();
        chk("sw_memwr", {28'd0, state}, 32'd5);
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall_mem_write", {31'd0, mem_write}, 32'd1);
            chk("sw_stall_done", {31'd0, instr_done}, 32'd0);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("sw_last_mem_write", {31'd0, mem_write}, 32'd1);
        chk("sw_last_done", {31'd0, instr_done}, 32'd1);
        tick();
        chk("sw_back_fetch", {28'd0, state}, 32'd0);
        chk("sw_cycles", cycles, 32'd8);
        chk("sw_done_pulses", dones, 32'd1);

        // beq
        opcode = 6'b000100;
        tick(); tick();
        chk("beq_state", {28'd0, state}, 32'd8);
        zero = 1'b1; #1;
        chk("beq_taken_pc_en", {31'd0, pc_en}, 32'd1);
        chk("beq_taken_alu_op", {30'd0, alu_op}, 32'd1);
        chk("beq_pc_source", {30'd0, pc_source}, 32'd1);
        zero = 1'b0; #1;
        chk("beq_nt_pc_en", {31'd0, pc_en}, 32'd0);
        chk("beq_nt_alu_op", {30'd0, alu_op}, 32'd1);
        tick();
        chk("beq_back_fetch", {28'd0, state}, 32'd0);

        // R-type
        opcode = 6'b000000;
        tick(); tick();
        chk("r_exec_state", {28'd0, state}, 32'd6);
        chk("r_exec_alu_op", {30'd0, alu_op}, 32'd2);
        tick();
        chk("r_rwb_state", {28'd0, state}, 32'd7);
        chk("r_rwb_reg_dst", {31'd0, reg_dst}, 32'd1);
        chk("r_rwb_reg_write", {31'd0, reg_write}, 32'd1);
        tick();

        // j
        opcode = 6'b000010;
        tick(); tick();
        chk("j_state", {28'd0, state}, 32'd9);
        chk("j_pc_en", {31'd0, pc_en}, 32'd1);
        chk("j_pc_source", {30'd0, pc_source}, 32'd2);
        tick();
        chk("j_back_fetch", {28'd0, state}, 32'd0);

        // addi
        opcode = 6'b001000;
        tick(); tick();
`ifdef MC_CTRL_ADDI_EN
        chk("addi_ex_state", {28'd0, state}, 32'd10);
        chk("addi_ex_alu_op", {30'd0, alu_op}, 32'd0);
        chk("addi_ex_alu_src_b", {30'd0, alu_src_b}, 32'd2);
        tick();
        chk("addi_wb_state", {28'd0, state}, 32'd11);
        chk("addi_wb_reg_write", {31'd0, reg_write}, 32'd1);
        chk("addi_wb_reg_dst", {31'd0, reg_dst}, 32'd0);
        tick();
        chk("addi_back_fetch", {28'd0, state}, 32'd0);
`else
        chk("addi_off_state", {28'd0, state}, 32'd15);
        chk("addi_off_illegal", {31'd0, illegal}, 32'd1);
        rst = 1'b1; #1;
        chk("addi_off_rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
`endif

        // Unsupported opcode, held for a dozen cycles
        opcode = 6'b111111;
        tick(); tick();
        for (int i = 0; i < 12; i++) begin
            chk("ill_state", {28'd0, state}, 32'd15);
            chk("ill_flag", {31'd0, illegal}, 32'd1);
            chk("ill_strobes", {21'd0, strobes}, 32'd0);
            mem_ready = ~mem_ready;
            tick();
        end
        rst = 1'b1; #1;
        chk("ill_rst_flag", {31'd0, illegal}, 32'd0);
        chk("ill_rst_state", {28'd0, state}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; mem_ready = 1'b1; #1;
        chk("ill_rel_mem_read", {31'd0, mem_read}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
